// File: rtl/aes_inv_subbytes_iter.sv
// Iterative AES InvSubBytes: applies the FIPS-197 inverse S-box to a 128-bit state,
// BYTES_PER_CYCLE bytes per clock, with valid/ready handshakes on both sides.
module aes_inv_subbytes_iter #(
  parameter int BYTES_PER_CYCLE = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_state,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_state
);

  localparam int NCHUNK  = 16 / BYTES_PER_CYCLE;
  localparam int CNT_W   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam int CHUNK_W = 8 * BYTES_PER_CYCLE;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NCHUNK - 1);

  generate
    if (BYTES_PER_CYCLE != 1 && BYTES_PER_CYCLE != 2 && BYTES_PER_CYCLE != 4 &&
        BYTES_PER_CYCLE != 8 && BYTES_PER_CYCLE != 16) begin : g_bad_bpc
      $fatal(1, "aes_inv_subbytes_iter: BYTES_PER_CYCLE must be 1, 2, 4, 8 or 16");
    end
  endgenerate

  // Inverse S-box, entry 0 first (index 0 is the most significant element).
  localparam logic [0:255][7:0] INV_SBOX = {
    128'h52096ad53036a538bf40a39e81f3d7fb,
    128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e,
    128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692,
    128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506,
    128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673,
    128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b,
    128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f,
    128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961,
    128'h172b047eba77d626e169146355210c7d
  };

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             state, state_next;
  logic [CNT_W-1:0]   cnt;
  logic [127:0]       buffer;
  logic [6:0]         bit_base;
  logic [CHUNK_W-1:0] chunk_in;
  logic [CHUNK_W-1:0] chunk_out;

  assign bit_base = 7'(int'(cnt) * CHUNK_W);
  assign chunk_in = buffer[bit_base +: CHUNK_W];

  for (genvar i = 0; i < BYTES_PER_CYCLE; i++) begin : g_rom
    assign chunk_out[8*i +: 8] = INV_SBOX[chunk_in[8*i +: 8]];
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      buffer <= '0;
    end else begin
      state <= state_next;
      case (state)
        IDLE: begin
          if (in_valid) begin
            buffer <= in_state;
            cnt    <= '0;
          end
        end
        RUN: begin
          buffer[bit_base +: CHUNK_W] <= chunk_out;
          cnt <= (cnt == CNT_LAST) ? '0 : cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    case (state)
      IDLE: begin
        in_ready = !rst;
        if (in_valid && !rst) state_next = RUN;
      end
      RUN: begin
        if (cnt == CNT_LAST) state_next = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // The buffer is only loaded in IDLE and only rewritten in RUN, so it is stable in DONE.
  assign out_state = buffer;

endmodule

// File: tb/tb_aes_inv_subbytes_iter.sv
// Bench for aes_inv_subbytes_iter: three instances (4, 1 and 16 bytes per cycle) share stimulus
// and are compared against an S-box derived from GF(2^8) arithmetic.
module tb_aes_inv_subbytes_iter;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic [127:0] in_state;
  logic         out_ready;
  logic [2:0]   in_ready_v;
  logic [2:0]   out_valid_v;
  logic [127:0] out_state_v [3];

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] fwd_tab [256];
  logic [7:0] inv_tab [256];

  always #5 clk = ~clk;

  aes_inv_subbytes_iter #(.BYTES_PER_CYCLE(4)) u_bpc4 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_v[0]), .in_state(in_state),
    .out_valid(out_valid_v[0]), .out_ready(out_ready), .out_state(out_state_v[0]));
  aes_inv_subbytes_iter #(.BYTES_PER_CYCLE(1)) u_bpc1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_v[1]), .in_state(in_state),
    .out_valid(out_valid_v[1]), .out_ready(out_ready), .out_state(out_state_v[1]));
  aes_inv_subbytes_iter #(.BYTES_PER_CYCLE(16)) u_bpc16 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_v[2]), .in_state(in_state),
    .out_valid(out_valid_v[2]), .out_ready(out_ready), .out_state(out_state_v[2]));

  function automatic int bpc(input int d);
    return (d == 0) ? 4 : (d == 1) ? 1 : 16;
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] b, input int n);
    return (b << n) | (b >> (8 - n));
  endfunction

  // S-box = affine map of the multiplicative inverse; the inverse table is its permutation inverse.
  task automatic build_tables();
    for (int a = 0; a < 256; a++) begin
      logic [7:0] inv;
      logic [7:0] s;
      inv = 8'h00;
      for (int b = 1; b < 256; b++)
        if (gmul(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
      s = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
      fwd_tab[a] = s;
      inv_tab[s] = 8'(a);
    end
  endtask

  function automatic logic [127:0] inv_sub(input logic [127:0] s);
    logic [127:0] r;
    for (int i = 0; i < 16; i++) r[8*i +: 8] = inv_tab[s[8*i +: 8]];
    return r;
  endfunction

  function automatic logic [127:0] fwd_sub(input logic [127:0] s);
    logic [127:0] r;
    for (int i = 0; i < 16; i++) r[8*i +: 8] = fwd_tab[s[8*i +: 8]];
    return r;
  endfunction

  function automatic logic [127:0] rand_state();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Waits until all instances are idle, then presents s for exactly one accepting edge.
  task automatic send(input logic [127:0] s);
    bit ready_seen;
    ready_seen = 1'b0;
    in_valid = 1'b0;
    for (int w = 0; w < 60 && !ready_seen; w++) begin
      @(negedge clk);
      if (&in_ready_v) ready_seen = 1'b1;
    end
    n_checks++;
    if (!ready_seen) begin
      n_fail++;
      $display("FAIL send_ready: in_ready=%b never reached 111 within 60 cycles", in_ready_v);
    end
    in_state = s;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_state = rand_state();
  endtask

  // Called just after the accepting edge; records the edge count at which each out_valid rises.
  task automatic collect(input logic [127:0] exp, input string name);
    bit seen [3];
    for (int d = 0; d < 3; d++) seen[d] = 1'b0;
    for (int e = 0; e <= 40 && !(seen[0] && seen[1] && seen[2]); e++) begin
      @(negedge clk);
      for (int d = 0; d < 3; d++) begin
        if (!seen[d] && out_valid_v[d]) begin
          seen[d] = 1'b1;
          n_checks++;
          if (out_state_v[d] !== exp) begin
            n_fail++;
            $display("FAIL %s_state bpc=%0d: got %h expected %h", name, bpc(d), out_state_v[d], exp);
          end
          n_checks++;
          if (e != 16 / bpc(d)) begin
            n_fail++;
            $display("FAIL %s_latency bpc=%0d: got %0d edges expected %0d", name, bpc(d), e, 16 / bpc(d));
          end
        end
      end
      @(posedge clk);
    end
    #1;
    for (int d = 0; d < 3; d++) begin
      if (!seen[d]) begin
        n_checks++;
        n_fail++;
        $display("FAIL %s_timeout bpc=%0d: out_valid never rose within 40 cycles", name, bpc(d));
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    in_state = rand_state();
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      n_checks++;
      if (in_ready_v[d] !== 1'b0 || out_valid_v[d] !== 1'b0 || out_state_v[d] !== 128'h0) begin
        n_fail++;
        $display("FAIL reset_state bpc=%0d: in_ready=%b out_valid=%b out_state=%h expected 0 0 0",
                 bpc(d), in_ready_v[d], out_valid_v[d], out_state_v[d]);
      end
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      n_checks++;
      if (in_ready_v[d] !== 1'b1) begin
        n_fail++;
        $display("FAIL reset_release bpc=%0d: in_ready=%b expected 1", bpc(d), in_ready_v[d]);
      end
    end
  endtask

  task automatic test_known_vectors();
    out_ready = 1'b1;
    send({16{8'h63}});
    collect(128'h0, "all_63");
    send(128'h0f0e0d0c0b0a09080706050403020100);
    collect(128'hfbd7f3819ea340bf38a53630d56a0952, "counting");
  endtask

  task automatic test_round_trip();
    int order [16];
    out_ready = 1'b1;
    for (int k = 0; k < 16; k++) order[k] = k;
    for (int k = 15; k > 0; k--) begin
      int j;
      int t;
      j = int'($urandom_range(k, 0));
      t = order[k];
      order[k] = order[j];
      order[j] = t;
    end
    for (int k = 0; k < 16; k++) begin
      logic [127:0] orig;
      for (int j = 0; j < 16; j++) orig[8*j +: 8] = 8'(order[k] * 16 + j);
      send(fwd_sub(orig));
      collect(orig, "round_trip");
    end
  endtask

  task automatic test_random();
    out_ready = 1'b1;
    for (int k = 0; k < 12; k++) begin
      logic [127:0] s;
      s = rand_state();
      send(s);
      collect(inv_sub(s), "random");
    end
  endtask

  task automatic test_backpressure();
    logic [127:0] s1;
    logic [127:0] s2;
    s1 = rand_state();
    s2 = rand_state();
    out_ready = 1'b0;
    send(s1);
    collect(inv_sub(s1), "bp_first");
    in_state = s2;
    in_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      for (int d = 0; d < 3; d++) begin
        n_checks++;
        if (out_valid_v[d] !== 1'b1 || in_ready_v[d] !== 1'b0 || out_state_v[d] !== inv_sub(s1)) begin
          n_fail++;
          $display("FAIL bp_hold bpc=%0d cycle=%0d: out_valid=%b in_ready=%b out_state=%h expected 1 0 %h",
                   bpc(d), c, out_valid_v[d], in_ready_v[d], out_state_v[d], inv_sub(s1));
        end
      end
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      n_checks++;
      if (out_valid_v[d] !== 1'b0 || in_ready_v[d] !== 1'b1) begin
        n_fail++;
        $display("FAIL bp_release bpc=%0d: out_valid=%b in_ready=%b expected 0 1",
                 bpc(d), out_valid_v[d], in_ready_v[d]);
      end
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_state = rand_state();
    collect(inv_sub(s2), "bp_second");
  endtask

  task automatic test_reset_mid_run();
    logic [127:0] s;
    bit stale;
    out_ready = 1'b0;
    send(rand_state());
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      n_checks++;
      if (out_valid_v[d] !== 1'b0 || in_ready_v[d] !== 1'b1) begin
        n_fail++;
        $display("FAIL abort_state bpc=%0d: out_valid=%b in_ready=%b expected 0 1",
                 bpc(d), out_valid_v[d], in_ready_v[d]);
      end
    end
    out_ready = 1'b1;
    stale = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (out_valid_v !== 3'b000) stale = 1'b1;
    end
    n_checks++;
    if (stale) begin
      n_fail++;
      $display("FAIL abort_stale: out_valid rose after abort, got 1 expected 0");
    end
    @(posedge clk);
    #1;
    s = rand_state();
    send(s);
    collect(inv_sub(s), "after_abort");
  endtask

  initial begin
    build_tables();
    test_reset();
    test_known_vectors();
    test_round_trip();
    test_random();
    test_backpressure();
    test_reset_mid_run();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
